reset_sequencer: RTL and testbench

- Generates the staged reset that the design's flops consume.
- Takes the raw asynchronous reset `rst` and asserts every reset output immediately, without waiting for a clock.
- Releases the outputs synchronously to `clk`, one stage at a time in a fixed order, so downstream blocks come out of reset in sequence.
- Also provides a handshaked software reset request that re-runs the release sequence without touching `rst`.
- Sits at the top of the clock domain, between the board/POR reset and all sync- and async-reset register banks.

---
 rtl/reset_sequencer.sv | 113 +++++++++++
 tb/tb_reset_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset generator: asserts every reset output asynchronously, then
// releases them one at a time, synchronously to clk, with a software re-run path.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req_i,
  output logic [NUM_STAGES-1:0] rst_o,
  output logic                  ready_o,
  output logic                  sw_ack_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_HOLD,
    ST_STAGE,
    ST_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [NUM_STAGES-1:0]   rst_o_q, rst_o_d;
  logic                    ready_q, ready_d;
  logic                    sw_ack_q, sw_ack_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b0};
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

  // SYNC watches the bit feeding the last chain stage so HOLD is entered on
  // the very edge the synchronized reset clears.
  // Releasing a stage is a left shift: outputs stay a run of ones at the top.
  always_comb begin
    state_d  = state_q;
    rst_o_d  = rst_o_q;
    ready_d  = ready_q;
    sw_ack_d = 1'b0;
    cnt_d    = cnt_inc;
    unique case (state_q)
      ST_SYNC: begin
        cnt_d = '0;
        if (!sync_q[SYNC_STAGES-2]) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_STAGE;
          rst_o_d = rst_o_q << 1;
          cnt_d   = '0;
        end
      end
      ST_STAGE: begin
        if (rst_o_q == '0) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          rst_o_d = rst_o_q << 1;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (sw_rst_req_i) begin
          state_d  = ST_HOLD;
          rst_o_d  = '1;
          ready_d  = 1'b0;
          sw_ack_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_SYNC;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SYNC;
      sync_q   <= '1;
      rst_o_q  <= '1;
      ready_q  <= 1'b0;
      sw_ack_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      rst_o_q  <= rst_o_d;
      ready_q  <= ready_d;
      sw_ack_q <= sw_ack_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rst_o    = rst_o_q;
  assign ready_o  = ready_q;
  assign sw_ack_o = sw_ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a minimal-parameter instance,
// both checked every edge against a timing model counted from E0 or the accept edge.
module tb_reset_sequencer;

  localparam int S1 = 2, H1 = 16, N1 = 3, G1 = 4;
  localparam int S2 = 3, H2 = 1,  N2 = 1, G2 = 1;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          swReq = 1'b0;
  logic [N1-1:0] rstO1;
  logic          ready1, ack1;
  logic [N2-1:0] rstO2;
  logic          ready2, ack2;

  int compared   = 0;
  int mismatched = 0;

  bit            pendRst   = 1'b1;
  bit            sw1       = 1'b0;
  int            t1        = 0;
  int            t2        = 0;
  logic [N1-1:0] exp1      = '1;
  logic          expReady1 = 1'b0;
  logic          expAck1   = 1'b0;
  logic [N2-1:0] exp2      = '1;
  logic          expReady2 = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES(S1), .HOLD_CYCLES(H1), .NUM_STAGES(N1), .STAGE_GAP(G1)
  ) dut (
    .clk(clk), .rst(rst), .sw_rst_req_i(swReq),
    .rst_o(rstO1), .ready_o(ready1), .sw_ack_o(ack1)
  );

  reset_sequencer #(
    .SYNC_STAGES(S2), .HOLD_CYCLES(H2), .NUM_STAGES(N2), .STAGE_GAP(G2)
  ) dutSweep (
    .clk(clk), .rst(rst), .sw_rst_req_i(1'b0),
    .rst_o(rstO2), .ready_o(ready2), .sw_ack_o(ack2)
  );

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
    end
  endtask

  // Stage k is still held while fewer than lat + k*gap edges have passed.
  function automatic logic [7:0] relMask(input int t, input int lat, input int n, input int gap);
    logic [7:0] m;
    m = '0;
    for (int k = 0; k < n; k++) begin
      if (t < lat + k * gap) m[k] = 1'b1;
    end
    return m;
  endfunction

  task automatic computeExp();
    logic [7:0] m;
    int lat;
    lat       = sw1 ? H1 : (S1 - 1 + H1);
    m         = relMask(t1, lat, N1, G1);
    exp1      = m[N1-1:0];
    expReady1 = (t1 >= lat + (N1 - 1) * G1 + 1);
    expAck1   = sw1 && (t1 == 0);
    lat       = S2 - 1 + H2;
    m         = relMask(t2, lat, N2, G2);
    exp2      = m[N2-1:0];
    expReady2 = (t2 >= lat + (N2 - 1) * G2 + 1);
  endtask

  task automatic checkAll();
    checkOutput("rst_o", 8'(rstO1), 8'(exp1));
    checkOutput("ready_o", 8'(ready1), 8'(expReady1));
    checkOutput("sw_ack_o", 8'(ack1), 8'(expAck1));
    checkOutput("sweep_rst_o", 8'(rstO2), 8'(exp2));
    checkOutput("sweep_ready_o", 8'(ready2), 8'(expReady2));
    checkOutput("sweep_sw_ack_o", 8'(ack2), 8'h00);
  endtask

  // Reference model: a rising rst forces reset values at once; each clock edge
  // either starts a new count (E0 or an accepted request) or advances it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pendRst   = 1'b1;
      exp1      = '1;
      expReady1 = 1'b0;
      expAck1   = 1'b0;
      exp2      = '1;
      expReady2 = 1'b0;
    end else begin
      if (pendRst) begin
        pendRst = 1'b0;
        sw1     = 1'b0;
        t1      = 0;
        t2      = 0;
      end else begin
        if (expReady1 && swReq) begin
          sw1 = 1'b1;
          t1  = 0;
        end else if (t1 < 1000) begin
          t1++;
        end
        if (t2 < 1000) t2++;
      end
      computeExp();
    end
    #1;
    checkAll();
  end

  task automatic applyStimulus(input int kind, input int len);
    case (kind)
      0: begin
        swReq = 1'b1;
        repeat (len) @(negedge clk);
        swReq = 1'b0;
      end
      1: begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
      default: begin
        #2 rst = 1'b1;
        repeat (len) @(negedge clk);
        rst = 1'b0;
      end
    endcase
  endtask

  initial begin
    int gap, kind, len;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Request during HOLD must be ignored.
    repeat (10) @(negedge clk);
    applyStimulus(0, 2);
    repeat (25) @(negedge clk);

    // Single-cycle request in RUN, then a request held across a whole sequence.
    applyStimulus(0, 1);
    repeat (35) @(negedge clk);
    applyStimulus(0, 30);
    repeat (35) @(negedge clk);

    // Reset between E19 and E20, then a half-cycle glitch in RUN.
    applyStimulus(2, 2);
    repeat (20) @(negedge clk);
    applyStimulus(2, 2);
    repeat (35) @(negedge clk);
    applyStimulus(1, 0);
    repeat (35) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      gap  = $urandom_range(1, 40);
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 3);
      repeat (gap) @(negedge clk);
      if (kind < 6)      applyStimulus(0, len);
      else if (kind < 8) applyStimulus(1, 0);
      else               applyStimulus(2, len);
    end

    repeat (40) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
